// File: rtl/maxpool2d_if.sv
// Handshake and data bundle between the conv/ReLU stage and the max-pooling stage.
interface maxpool2d_if #(
  parameter int unsigned SIZE      = 5,
  parameter int unsigned POOL      = 2,
  parameter int unsigned WIDTH_BIT = 8
);
  localparam int unsigned OUT = SIZE / POOL;

  logic                                        start;
  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]    inpMatrix;
  logic                                        busy;
  logic                                        done;
  logic [OUT-1:0][OUT-1:0][WIDTH_BIT-1:0]      poolOut;

  modport master (output start, inpMatrix, input busy, done, poolOut);
  modport slave  (input start, inpMatrix, output busy, done, poolOut);
endinterface

// File: rtl/maxpool2d.sv
// Non-overlapping POOL x POOL max-pooling over a snapshot of the conv feature map,
// one element per cycle, results written in raster order then a one-cycle done pulse.
module maxpool2d #(
  parameter int unsigned SIZE      = 5,
  parameter int unsigned POOL      = 2,
  parameter int unsigned WIDTH_BIT = 8
) (
  input  logic        clock,
  input  logic        nreset,
  maxpool2d_if.slave  bus
);
  localparam int unsigned OUT = SIZE / POOL;
  localparam int unsigned PP  = POOL * POOL;
  localparam int unsigned KW  = (PP  > 1) ? $clog2(PP)  : 1;
  localparam int unsigned RW  = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int unsigned IW  = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_DONE} state_t;

  state_t r_state, w_state_nxt;
  logic   r_start_q, r_busy, r_done;
  logic   w_busy_d, w_done_d;
  logic   w_trig, w_last_k, w_last_c, w_last_r;

  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] r_snap;
  logic [OUT-1:0][OUT-1:0][WIDTH_BIT-1:0]   r_pool;
  logic signed [WIDTH_BIT-1:0]              r_max;
  logic signed [WIDTH_BIT-1:0]              w_elem;
  logic [KW-1:0]                            r_k;
  logic [RW-1:0]                            r_r, r_c;
  logic [IW-1:0]                            w_er, w_ec;
  int unsigned                              w_row_i, w_col_i;

  assign w_trig   = bus.start & ~r_start_q;
  assign w_last_k = (r_k == KW'(PP - 1));
  assign w_last_c = (r_c == RW'(OUT - 1));
  assign w_last_r = (r_r == RW'(OUT - 1));

  // Element k of the current window, row-major inside the window.
  always_comb begin
    w_row_i = 32'(r_r) * POOL + 32'(r_k) / POOL;
    w_col_i = 32'(r_c) * POOL + 32'(r_k) % POOL;
    w_er    = IW'(w_row_i);
    w_ec    = IW'(w_col_i);
    w_elem  = r_snap[w_er][w_ec];
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= bus.start;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_trig) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_last_k) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = (w_last_r && w_last_c) ? S_DONE : S_SCAN;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_d = r_busy;
    w_done_d = 1'b0;
    case (r_state)
      S_IDLE:  if (w_trig) w_busy_d = 1'b1;
      S_WRITE: w_done_d = w_last_r && w_last_c;
      S_DONE:  w_busy_d = 1'b0;
      default: ;
    endcase
  end

  // Snapshot, window counters, running max and the registered output map.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_snap <= '0;
      r_pool <= '0;
      r_max  <= '0;
      r_k    <= '0;
      r_r    <= '0;
      r_c    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_trig) begin
          r_snap <= bus.inpMatrix;
          r_k    <= '0;
          r_r    <= '0;
          r_c    <= '0;
        end
        S_SCAN: begin
          r_max <= ((r_k == '0) || (w_elem > r_max)) ? w_elem : r_max;
          if (!w_last_k) r_k <= r_k + KW'(1);
        end
        S_WRITE: begin
          r_pool[r_r][r_c] <= r_max;
          r_k              <= '0;
          if (w_last_c) begin
            r_c <= '0;
            r_r <= r_r + RW'(1);
          end else begin
            r_c <= r_c + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.poolOut = r_pool;
endmodule

// File: tb/tb_maxpool2d.sv
// Self-checking bench for maxpool2d: table vectors, random maps against a loop model,
// and hand-written sequences for reset, held start and disturbance while busy.
module tb_maxpool2d;
  localparam int SIZE = 5;
  localparam int POOL = 2;
  localparam int OUT  = SIZE / POOL;

  logic clk;
  logic nreset;

  maxpool2d_if #(.SIZE(SIZE), .POOL(POOL), .WIDTH_BIT(8)) u_if ();
  maxpool2d #(.SIZE(SIZE), .POOL(POOL), .WIDTH_BIT(8)) u_dut (
    .clock  (clk),
    .nreset (nreset),
    .bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string name;
    int    kind;
    int    exp[OUT*OUT];
  } vec_t;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic build(input int kind, output int m[SIZE][SIZE]);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        case (kind)
          0: m[r][c] = 5*r + c;
          1: m[r][c] = 0;
          2: m[r][c] = -128;
          3: m[r][c] = -(5*r + c);
          default: m[r][c] = (r == SIZE-1 || c == SIZE-1) ? 100 : 0;
        endcase
    if (kind == 1) begin
      m[0][0] = -3; m[0][1] = -1; m[1][0] = -7; m[1][1] = -2;
    end
  endtask

  task automatic rand_map(output int m[SIZE][SIZE]);
    logic signed [7:0] b;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        b = 8'($urandom);
        m[r][c] = int'(b);
      end
  endtask

  // Reference: maximum over each non-overlapping window, trailing rows/cols dropped.
  task automatic ref_pool(input int m[SIZE][SIZE], output int e[OUT*OUT]);
    int mx;
    for (int r = 0; r < OUT; r++)
      for (int c = 0; c < OUT; c++) begin
        mx = -1000;
        for (int i = 0; i < POOL; i++)
          for (int j = 0; j < POOL; j++)
            if (m[r*POOL+i][c*POOL+j] > mx) mx = m[r*POOL+i][c*POOL+j];
        e[r*OUT+c] = mx;
      end
  endtask

  task automatic drive(input int m[SIZE][SIZE]);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        u_if.inpMatrix[r][c] = 8'(m[r][c]);
  endtask

  task automatic check_pool(input string nm, input int e[OUT*OUT]);
    logic signed [7:0] t;
    for (int r = 0; r < OUT; r++)
      for (int c = 0; c < OUT; c++) begin
        t = u_if.poolOut[r][c];
        chk($sformatf("%s_pool[%0d][%0d]", nm, r, c), int'(t), e[r*OUT+c]);
      end
  endtask

  // One run from a start rising edge; checks done timing, pulse count and busy.
  task automatic do_run(input string nm, input int m[SIZE][SIZE], input bit hold, input bit disturb);
    int pulses = 0;
    int first  = 0;
    int all127[SIZE][SIZE];
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) all127[r][c] = 127;
    drive(m);
    @(negedge clk);
    u_if.start = 1'b1;
    @(posedge clk);
    #1 chk({nm, "_busy_rise"}, int'(u_if.busy), 1);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (disturb) begin
        if (n == 1) begin drive(all127); u_if.start = 1'b0; end
        if (n == 2) u_if.start = 1'b1;
        if (n == 3) u_if.start = 1'b0;
      end else if (!hold && n == 1) begin
        u_if.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (u_if.done) begin
        pulses++;
        if (first == 0) first = n;
      end
      if (n == 20) chk({nm, "_busy_e20"}, int'(u_if.busy), 1);
      if (n == 21) chk({nm, "_busy_e21"}, int'(u_if.busy), 0);
    end
    chk({nm, "_done_pulses"}, pulses, 1);
    chk({nm, "_done_edge"}, first, 20);
    @(negedge clk);
    u_if.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    int z[OUT*OUT];
    for (int i = 0; i < OUT*OUT; i++) z[i] = 0;
    chk({nm, "_busy"}, int'(u_if.busy), 0);
    chk({nm, "_done"}, int'(u_if.done), 0);
    check_pool(nm, z);
  endtask

  vec_t vecs[5];
  int   m[SIZE][SIZE];
  int   e[OUT*OUT];

  initial begin
    vecs[0] = '{name: "ramp",     kind: 0, exp: '{6, 8, 16, 18}};
    vecs[1] = '{name: "signedwin", kind: 1, exp: '{-1, 0, 0, 0}};
    vecs[2] = '{name: "allneg",   kind: 2, exp: '{-128, -128, -128, -128}};
    vecs[3] = '{name: "negramp",  kind: 3, exp: '{0, -2, -10, -12}};
    vecs[4] = '{name: "trailing", kind: 4, exp: '{0, 0, 0, 0}};

    nreset = 1'b0;
    u_if.start = 1'b0;
    u_if.inpMatrix = '0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    nreset = 1'b1;

    for (int v = 0; v < 5; v++) begin
      build(vecs[v].kind, m);
      do_run(vecs[v].name, m, 1'b0, 1'b0);
      check_pool(vecs[v].name, vecs[v].exp);
    end

    // Asynchronous reset mid-clock with start high.
    build(0, m);
    drive(m);
    @(negedge clk);
    u_if.start = 1'b1;
    @(posedge clk);
    #2 nreset = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    u_if.start = 1'b0;
    nreset = 1'b1;

    // Held start gives one pulse; a fresh edge gives an identical second run.
    build(0, m);
    ref_pool(m, e);
    do_run("held", m, 1'b1, 1'b0);
    check_pool("held", e);
    do_run("rerun", m, 1'b0, 1'b0);
    check_pool("rerun", e);

    // Input changes and extra start edges while busy are ignored.
    rand_map(m);
    ref_pool(m, e);
    do_run("disturb", m, 1'b0, 1'b1);
    check_pool("disturb", e);

    for (int i = 0; i < 4; i++) begin
      rand_map(m);
      ref_pool(m, e);
      do_run($sformatf("rand%0d", i), m, 1'b0, 1'b0);
      check_pool($sformatf("rand%0d", i), e);
    end

    // Reset at E0+7 aborts the run; the next start produces a clean result.
    build(3, m);
    drive(m);
    @(negedge clk);
    u_if.start = 1'b1;
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1 nreset = 1'b0;
    #1 check_reset_outputs("midrun_rst");
    @(negedge clk);
    u_if.start = 1'b0;
    nreset = 1'b1;
    build(0, m);
    ref_pool(m, e);
    do_run("after_rst", m, 1'b0, 1'b0);
    check_pool("after_rst", e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
